// File: rtl/wave_dispatcher_pkg.sv
// rtl/wave_dispatcher_pkg.sv - shared state encodings and default sizes for wave_dispatcher
// Purpose: dispatcher FSM state type and default parameter values.
// Ports: none (package).

package wave_dispatcher_pkg;

  localparam int DEFAULT_NUM_SIMDS     = 4;
  localparam int DEFAULT_WAVE_ID_WIDTH = 8;

  typedef enum logic [1:0] {
    DISP_IDLE  = 2'd0,
    DISP_RUN   = 2'd1,
    DISP_DRAIN = 2'd2,
    DISP_DONE  = 2'd3
  } disp_state_t;

endpackage

// File: rtl/wave_dispatcher_rr_picker.sv
// rtl/wave_dispatcher_rr_picker.sv - round-robin idle SIMD picker
// Purpose: combinational search for the first idle SIMD at or after rr_ptr, wrapping.
// Ports:
//   idle    in  NUM_SIMDS  1 = SIMD may accept a wave
//   rr_ptr  in  PTR_W      search start index
//   valid   out 1          at least one SIMD is idle
//   pick    out PTR_W      chosen SIMD index (0 when valid=0)

module wave_dispatcher_rr_picker #(
  parameter int NUM_SIMDS = 4,
  parameter int PTR_W     = 2
) (
  input  logic [NUM_SIMDS-1:0] idle,
  input  logic [PTR_W-1:0]     rr_ptr,
  output logic                 valid,
  output logic [PTR_W-1:0]     pick
);

  // Scan offsets from farthest to nearest so the nearest idle SIMD wins.
  always_comb begin
    int idx;
    valid = 1'b0;
    pick  = '0;
    for (int k = NUM_SIMDS - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_SIMDS) idx = idx - NUM_SIMDS;
      if (idle[idx]) begin
        valid = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/wave_dispatcher.sv
// rtl/wave_dispatcher.sv - kernel-level wavefront scheduler for an array of SIMD controllers
// Purpose: on launch, issue one-cycle start pulses with wave IDs to idle SIMDs round-robin,
//          track per-SIMD busy state and raise kernel_done once every wave has completed.
// Optional: WAVE_DISPATCH_PERF_EN builds a saturating 32-bit kernel duration counter;
//           without it kernel_cycles is tied to 0.
// Ports:
//   clk, rst (async, active-low)
//   launch, total_waves      kernel launch request and wave count (sampled in DISP_IDLE)
//   simd_done                per-SIMD done level
//   simd_start               one-hot one-cycle start pulse
//   simd_wave_id             wave ID per SIMD, slice i belongs to SIMD i
//   busy_mask                SIMD owns an undone wave
//   dispatcher_busy          FSM in DISP_RUN or DISP_DRAIN
//   kernel_done              level, set on completion, cleared by next accepted launch
//   kernel_cycles            kernel duration in cycles

module wave_dispatcher
  import wave_dispatcher_pkg::*;
#(
  parameter int NUM_SIMDS     = DEFAULT_NUM_SIMDS,
  parameter int WAVE_ID_WIDTH = DEFAULT_WAVE_ID_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               launch,
  input  logic [WAVE_ID_WIDTH-1:0]           total_waves,
  input  logic [NUM_SIMDS-1:0]               simd_done,
  output logic [NUM_SIMDS-1:0]               simd_start,
  output logic [NUM_SIMDS*WAVE_ID_WIDTH-1:0] simd_wave_id,
  output logic [NUM_SIMDS-1:0]               busy_mask,
  output logic                               dispatcher_busy,
  output logic                               kernel_done,
  output logic [31:0]                        kernel_cycles
);

  localparam int PTR_W = (NUM_SIMDS > 1) ? $clog2(NUM_SIMDS) : 1;

  disp_state_t              state, state_nxt;
  logic [WAVE_ID_WIDTH-1:0] total_q, dispatched, completed, comp_cnt;
  logic [PTR_W-1:0]         rr_ptr, pick;
  logic                     pick_valid, do_pick, accept;
  logic [NUM_SIMDS-1:0]     comp, pick_oh;

  wave_dispatcher_rr_picker #(
    .NUM_SIMDS (NUM_SIMDS),
    .PTR_W     (PTR_W)
  ) u_picker (
    .idle   (~busy_mask),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .pick   (pick)
  );

  assign accept          = (state == DISP_IDLE) && launch;
  assign dispatcher_busy = (state == DISP_RUN) || (state == DISP_DRAIN);

  always_comb begin
    // A SIMD's done level from its previous wave is still high in the cycle its
    // new start pulse is out, so the pulse masks it.
    comp = '0;
    if (state != DISP_IDLE) comp = busy_mask & simd_done & ~simd_start;

    comp_cnt = '0;
    for (int i = 0; i < NUM_SIMDS; i++) comp_cnt = comp_cnt + WAVE_ID_WIDTH'(comp[i]);

    // Picker sees the pre-edge busy_mask: a SIMD freed this cycle waits one cycle.
    do_pick = (state == DISP_RUN) && (dispatched < total_q) && pick_valid;
    pick_oh = '0;
    for (int i = 0; i < NUM_SIMDS; i++) pick_oh[i] = do_pick && (pick == PTR_W'(i));

    state_nxt = state;
    case (state)
      DISP_IDLE:  if (launch) state_nxt = (total_waves == '0) ? DISP_DONE : DISP_RUN;
      DISP_RUN:   if (do_pick && (dispatched + 1'b1 == total_q)) state_nxt = DISP_DRAIN;
      DISP_DRAIN: if (completed + comp_cnt == total_q) state_nxt = DISP_DONE;
      DISP_DONE:  state_nxt = DISP_IDLE;
      default:    state_nxt = DISP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= DISP_IDLE;
      total_q      <= '0;
      dispatched   <= '0;
      completed    <= '0;
      rr_ptr       <= '0;
      busy_mask    <= '0;
      simd_start   <= '0;
      simd_wave_id <= '0;
      kernel_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      simd_start <= pick_oh;
      busy_mask  <= (busy_mask & ~comp) | pick_oh;
      for (int i = 0; i < NUM_SIMDS; i++)
        if (pick_oh[i]) simd_wave_id[i*WAVE_ID_WIDTH +: WAVE_ID_WIDTH] <= dispatched;

      if (accept) begin
        total_q     <= total_waves;
        dispatched  <= '0;
        completed   <= '0;
        kernel_done <= (total_waves == '0);
      end else begin
        completed <= completed + comp_cnt;
        if (do_pick) begin
          dispatched <= dispatched + 1'b1;
          rr_ptr     <= (pick == PTR_W'(NUM_SIMDS - 1)) ? '0 : pick + 1'b1;
        end
        if ((state == DISP_DRAIN) && (state_nxt == DISP_DONE)) kernel_done <= 1'b1;
      end
    end
  end

`ifdef WAVE_DISPATCH_PERF_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
    end else if (accept) begin
      cycle_cnt <= '0;
    end else if (dispatcher_busy && (cycle_cnt != '1)) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  assign kernel_cycles = cycle_cnt;
`else
  assign kernel_cycles = '0;
`endif

endmodule

// File: tb/tb_wave_dispatcher.sv
// tb/tb_wave_dispatcher.sv - self-checking bench for wave_dispatcher

module tb_wave_dispatcher;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           launch;
  logic [W-1:0]   total_waves;
  logic [N-1:0]   simd_done;
  logic [N-1:0]   simd_start;
  logic [N*W-1:0] simd_wave_id;
  logic [N-1:0]   busy_mask;
  logic           dispatcher_busy;
  logic           kernel_done;
  logic [31:0]    kernel_cycles;

  wave_dispatcher #(.NUM_SIMDS(N), .WAVE_ID_WIDTH(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .launch          (launch),
    .total_waves     (total_waves),
    .simd_done       (simd_done),
    .simd_start      (simd_start),
    .simd_wave_id    (simd_wave_id),
    .busy_mask       (busy_mask),
    .dispatcher_busy (dispatcher_busy),
    .kernel_done     (kernel_done),
    .kernel_cycles   (kernel_cycles)
  );

  always #5 clk = ~clk;

  typedef struct { int simd; int id; } sb_t;
  typedef struct { int total; int delay; bit relaunch; int exp_pulses; } vec_t;

  sb_t  sb[$];
  vec_t vecs[7];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cycle   = 0;
  int   pulse_cnt;
  int   last_raise;
  int   ref_rr;
  int   delay_cfg;
  bit   auto_mode = 1'b0;
  int   cnt[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; pulses are compared against the scoreboard, then the SIMD model reacts.
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    if (simd_start != '0) begin
      pulse_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_pulse", 64'(simd_start), 64'(0));
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("pulse_simd", 64'(simd_start), 64'(1 << e.simd));
        check("pulse_id", 64'(simd_wave_id[e.simd*W +: W]), 64'(e.id));
      end
    end
    if (auto_mode) begin
      for (int i = 0; i < N; i++) begin
        if (simd_start[i]) begin
          simd_done[i] = 1'b0;
          cnt[i] = delay_cfg;
        end else if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            simd_done[i] = 1'b1;
            last_raise = cycle;
          end
        end
      end
    end
  endtask

  task automatic run_kernel(input vec_t v);
    int c0;
    int n;
    int exp_kc;
    pulse_cnt  = 0;
    last_raise = -1;
    for (int k = 0; k < v.total; k++) sb.push_back('{(ref_rr + k) % N, k});
    ref_rr      = (ref_rr + v.total) % N;
    delay_cfg   = v.delay;
    auto_mode   = 1'b1;
    launch      = 1'b1;
    total_waves = W'(v.total);
    c0          = cycle;
    tick();
    launch = 1'b0;
    check("kdone_after_launch", 64'(kernel_done), 64'(v.total == 0));
    n = 0;
    while (!kernel_done && n < 3000) begin
      if (v.relaunch && cycle == c0 + 2) begin
        launch      = 1'b1;
        total_waves = W'(2);
      end else begin
        launch = 1'b0;
      end
      tick();
      n++;
    end
    launch = 1'b0;
    check("kdone_timeout", 64'(n < 3000), 64'(1));
    check("kdone_cycle", 64'(cycle), 64'((v.total == 0) ? c0 + 1 : last_raise + 1));
`ifdef WAVE_DISPATCH_PERF_EN
    exp_kc = (v.total == 0) ? 0 : last_raise - c0;
`else
    exp_kc = 0;
`endif
    check("kernel_cycles", 64'(kernel_cycles), 64'(exp_kc));
    check("busy_clear", 64'(busy_mask), 64'(0));
    tick();
    check("pulse_count", 64'(pulse_cnt), 64'(v.exp_pulses));
    check("sb_empty", 64'(sb.size()), 64'(0));
    check("kdone_held", 64'(kernel_done), 64'(1));
    check("idle_not_busy", 64'(dispatcher_busy), 64'(0));
    sb.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    int n;
    vecs[0] = '{0,   1, 1'b0, 0};
    vecs[1] = '{1,   3, 1'b0, 1};
    vecs[2] = '{10,  5, 1'b0, 10};
    vecs[3] = '{6,   4, 1'b1, 6};
    vecs[4] = '{4,   1, 1'b0, 4};
    vecs[5] = '{255, 3, 1'b0, 255};
    vecs[6] = '{7,   2, 1'b0, 7};
    for (int i = 0; i < N; i++) cnt[i] = 0;

    rst = 1'b0; launch = 1'b0; total_waves = '0; simd_done = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start", 64'(simd_start), 64'(0));
    check("rst_wave_id", 64'(simd_wave_id), 64'(0));
    check("rst_busy", 64'(busy_mask), 64'(0));
    check("rst_disp_busy", 64'(dispatcher_busy), 64'(0));
    check("rst_kdone", 64'(kernel_done), 64'(0));
    check("rst_kcycles", 64'(kernel_cycles), 64'(0));
    rst = 1'b1;
    tick();

    // Basic: four waves, done held low, strict 0..3 order.
    pulse_cnt = 0;
    for (int k = 0; k < 4; k++) sb.push_back('{k, k});
    launch = 1'b1; total_waves = 8'd4;
    tick();
    launch = 1'b0;
    check("basic_busy_run", 64'(dispatcher_busy), 64'(1));
    check("basic_no_early_pulse", 64'(simd_start), 64'(0));
    tick();
    check("basic_first_pulse", 64'(simd_start), 64'(4'b0001));
    repeat (3) tick();
    tick();
    check("basic_all_busy", 64'(busy_mask), 64'(4'b1111));
    check("basic_no_kdone", 64'(kernel_done), 64'(0));
    simd_done = 4'b1111;
    tick();
    check("basic_busy_clear", 64'(busy_mask), 64'(0));
    check("basic_kdone", 64'(kernel_done), 64'(1));
    tick();
    check("basic_idle", 64'(dispatcher_busy), 64'(0));
    check("basic_pulses", 64'(pulse_cnt), 64'(4));

    // Stale done: SIMD1 keeps its done level from the previous kernel.
    pulse_cnt = 0;
    simd_done = 4'b0010;
    sb.push_back('{0, 0});
    launch = 1'b1; total_waves = 8'd1;
    tick();
    launch = 1'b0;
    check("stale_kdone_cleared", 64'(kernel_done), 64'(0));
    repeat (5) tick();
    check("stale_no_kdone", 64'(kernel_done), 64'(0));
    check("stale_busy", 64'(busy_mask), 64'(4'b0001));
    simd_done[0] = 1'b1;
    tick();
    check("stale_kdone", 64'(kernel_done), 64'(1));
    check("stale_pulses", 64'(pulse_cnt), 64'(1));
    tick();
    ref_rr = 1;

    for (int v = 0; v < 7; v++) run_kernel(vecs[v]);

    // Reset mid-run after the third pulse.
    pulse_cnt = 0;
    for (int k = 0; k < 6; k++) sb.push_back('{(ref_rr + k) % N, k});
    delay_cfg = 30; auto_mode = 1'b1;
    launch = 1'b1; total_waves = 8'd6;
    tick();
    launch = 1'b0;
    n = 0;
    while (pulse_cnt < 3 && n < 20) begin
      tick();
      n++;
    end
    check("rst_mid_reach", 64'(pulse_cnt), 64'(3));
    #2 rst = 1'b0;
    #1;
    check("rst_mid_start", 64'(simd_start), 64'(0));
    check("rst_mid_busy", 64'(busy_mask), 64'(0));
    check("rst_mid_wave_id", 64'(simd_wave_id), 64'(0));
    check("rst_mid_disp", 64'(dispatcher_busy), 64'(0));
    check("rst_mid_kdone", 64'(kernel_done), 64'(0));
    sb.delete();
    auto_mode = 1'b0;
    simd_done = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    tick();
    rst = 1'b1;
    repeat (10) tick();
    check("rst_no_pulses", 64'(pulse_cnt), 64'(3));
    check("rst_idle", 64'(dispatcher_busy), 64'(0));

    // Simultaneous completions: SIMDs 1..3 finish together, SIMD1 picked next.
    pulse_cnt = 0;
    sb.push_back('{0, 0}); sb.push_back('{1, 1}); sb.push_back('{2, 2});
    sb.push_back('{3, 3}); sb.push_back('{1, 4});
    launch = 1'b1; total_waves = 8'd5;
    c0 = cycle;
    tick();
    launch = 1'b0;
    repeat (4) tick();
    tick();
    check("simul_full", 64'(busy_mask), 64'(4'b1111));
    check("simul_wait", 64'(simd_start), 64'(0));
    simd_done = 4'b1110;
    tick();
    check("simul_busy", 64'(busy_mask), 64'(4'b0001));
    check("simul_no_pulse", 64'(simd_start), 64'(0));
    tick();
    check("simul_pick", 64'(simd_start), 64'(4'b0010));
    check("simul_pick_cycle", 64'(cycle), 64'(c0 + 8));
    simd_done[1] = 1'b0;
    tick();
    check("simul_no_kdone", 64'(kernel_done), 64'(0));
    check("simul_busy2", 64'(busy_mask), 64'(4'b0011));
    simd_done = 4'b1111;
    tick();
    check("simul_kdone", 64'(kernel_done), 64'(1));
    check("simul_busy_clear", 64'(busy_mask), 64'(0));
    check("simul_pulses", 64'(pulse_cnt), 64'(5));
    check("simul_sb_empty", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wave_dispatcher.md
Name: wave_dispatcher

Overview:
- Kernel-level scheduler that distributes wavefronts across NUM_SIMDS SimdController instances.
- On a kernel launch it issues one-cycle simd_start pulses with a wave ID to idle SIMDs, chosen round-robin.
- It tracks per-SIMD busy state from simd_done and raises kernel_done once every wave has completed.
- Sits between the kernel launch/config interface and the SIMD array.

Parameters:
- NUM_SIMDS, 4, number of SIMD controllers served.
- WAVE_ID_WIDTH, 8, width of wave IDs and wave counters; max waves per kernel = 2^WAVE_ID_WIDTH-1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low (asserted when 0)
- launch  in  1  kernel launch request; sampled only in DISP_IDLE
- total_waves  in  WAVE_ID_WIDTH  waves in kernel; captured on accepted launch
- simd_done  in  NUM_SIMDS  per-SIMD done level; held high by the SIMD until its next start
- simd_start  out  NUM_SIMDS  one-hot, one-cycle start pulse
- simd_wave_id  out  NUM_SIMDS*WAVE_ID_WIDTH  wave ID per SIMD, slice i = SIMD i; stable while that SIMD is busy
- busy_mask  out  NUM_SIMDS  SIMD currently owns an undone wave
- dispatcher_busy  out  1  state != DISP_IDLE and != DISP_DONE
- kernel_done  out  1  level; set when all waves complete, cleared on next accepted launch
- kernel_cycles  out  32  kernel duration (optional feature)

Behaviour:
- Reset (rst=0, async): state=DISP_IDLE; all outputs 0; counters, RR pointer and captured total cleared.
- States: DISP_IDLE, DISP_RUN, DISP_DRAIN, DISP_DONE.
- DISP_IDLE, launch=1: capture total_waves, zero dispatched/completed counters, clear kernel_done.
  - Next state is DISP_RUN, or DISP_DONE if total_waves==0 (kernel_done=1 one cycle after launch).
- DISP_RUN, per cycle:
  - If dispatched<total and any SIMD has busy_mask=0, pick the first idle SIMD at or after rr_ptr (wrapping).
  - Register simd_start[pick]=1, simd_wave_id slice=dispatched, busy_mask[pick]=1, dispatched+1, rr_ptr=pick+1 mod NUM_SIMDS.
  - Dispatch rate is at most one wave per cycle; the first pulse is visible 2 cycles after the launch cycle.
  - When dispatched reaches total, go to DISP_DRAIN.
- Completion rule (all states except DISP_IDLE):
  - SIMD i completes when busy_mask[i] && simd_done[i] && !simd_start[i].
  - simd_start masking covers the stale done level from the previous wave.
  - busy_mask[i] clears at that edge; completed += number of SIMDs completing that cycle (multiple per cycle allowed).
- Same-cycle complete+pick: the picker uses the pre-edge busy_mask, so a just-freed SIMD is re-eligible the following cycle.
- DISP_DRAIN: when completed (including this cycle's completions) == total, set kernel_done=1 and go to DISP_DONE.
- DISP_DONE: next cycle go to DISP_IDLE; kernel_done stays 1 until the next accepted launch.
- launch outside DISP_IDLE is ignored; total_waves is not re-sampled.
- simd_done on a non-busy SIMD is ignored.
- Reset mid-kernel aborts immediately: busy_mask cleared, no further pulses. Downstream SIMDs are reset by the same rst.
- Counter widths are WAVE_ID_WIDTH bits; counters never wrap because total ≤ 2^W-1.

Optional Feature:
- Macro WAVE_DISPATCH_PERF_EN.
- Defined: a 32-bit counter clears on accepted launch and increments every cycle in DISP_RUN/DISP_DRAIN. It freezes at DISP_DONE, and kernel_cycles shows the frozen value. The counter saturates at 2^32-1.
- Undefined: kernel_cycles is tied to 0 and no counter logic is built.

Decomposition:
- Shared defs file holds:
  - state encodings DISP_IDLE=0, DISP_RUN=1, DISP_DRAIN=2, DISP_DONE=3 (2-bit);
  - default NUM_SIMDS and WAVE_ID_WIDTH.
- One sub-module: rr_picker.
  - Combinational; inputs are the idle mask and rr_ptr.
  - Outputs are valid and a pick index.
- Counters and FSM stay in wave_dispatcher.

Test Plan:
- Reset mid-run: launch total=6, assert rst=0 after the 3rd pulse -> all outputs 0 asynchronously; no pulses after release until a new launch.
- Basic: NUM_SIMDS=4, total=4, simd_done held 0 -> simd_start pulses 0001,0010,0100,1000 on consecutive cycles with IDs 0,1,2,3. Then raise all simd_done -> busy_mask 0, kernel_done=1 one cycle later.
- Oversubscribe: total=10, each SIMD done 5 cycles after its start pulse.
  - Expect 10 pulses, IDs 0..9 each exactly once, round-robin order.
  - kernel_done only after the 10th completion.
- Stale done: SIMD1 holds simd_done=1 from the prior kernel; launch total=1 -> SIMD0 chosen; SIMD1 level ignored; no premature kernel_done.
- Zero and ignored launch:
  - total=0 -> kernel_done=1 one cycle after launch, no pulses.
  - launch pulsed during DISP_RUN -> total unchanged.
- Simultaneous completions: 3 SIMDs drop busy on the same cycle -> completed +3; the next dispatch picks the lowest index at or after rr_ptr on the following cycle.
